// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher controller: FSM encoding,
// round-count constants and the byte/row helpers used by the inverse round.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box: inverse affine map, then multiplicative inverse as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] p;
    logic [7:0] r;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = t;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Row r is rotated right by r columns; byte (row r, col c) sits at index 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Ciphertext-in, plaintext-out and round-key fetch signals of the controller.
interface aes_inv_cipher_ctrl_if #(
  parameter int KIDX_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [KIDX_W-1:0] rk_idx;
  logic [127:0]      rk_data;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic              flush;
  logic              busy;

  modport master (
    output in_valid, in_data, rk_data, out_ready, flush,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk_data, out_ready, flush,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_mix_columns.sv
// InvMixColumns over a full 128-bit state, one column per 32-bit slice.
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] mixed
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed[127-32*c -: 32] = inv_mix_col(state[127-32*c -: 32]);
  end

endmodule

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  assign shifted = inv_shift_rows(state);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
  end

  assign keyed = subbed ^ round_key;

  aes_inv_mix_columns u_inv_mix_columns (
    .state (keyed),
    .mixed (mixed)
  );

  assign next_state = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES decryption controller: one inverse round per clock, round keys
// fetched by index from an external combinational key store.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_cipher_ctrl_if.slave   bus
);

  localparam logic [KIDX_W-1:0] NR_IDX  = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] IDX_ONE = KIDX_W'(1);

  fsm_t              fsm;
  logic [127:0]      state_q;
  logic [KIDX_W-1:0] rk_idx_q;
  logic [127:0]      out_data_q;
  logic [127:0]      round_out;
  logic              last;

  assign last = (rk_idx_q == '0);

  aes_inv_round u_inv_round (
    .state      (state_q),
    .round_key  (bus.rk_data),
    .last       (last),
    .next_state (round_out)
  );

  // NOTE: every register here updates with <= so all of them see the
  // pre-edge values of each other; the reset branch is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      state_q    <= '0;
      rk_idx_q   <= NR_IDX;
      out_data_q <= '0;
    end else if (bus.flush) begin
      fsm      <= IDLE;
      rk_idx_q <= NR_IDX;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_q  <= bus.in_data ^ bus.rk_data;
            rk_idx_q <= NR_IDX - IDX_ONE;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (last) begin
            out_data_q <= round_out;
            rk_idx_q   <= NR_IDX;
            fsm        <= DONE;
          end else begin
            rk_idx_q <= rk_idx_q - IDX_ONE;
          end
        end
        DONE: begin
          // Leaving DONE always passes through IDLE, so no accept happens here.
          if (bus.out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.busy      = (fsm != IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench: NR=10 and NR=14 controllers against FIPS-197 vectors, with
// a key-expansion model acting as the key store.
module tb_aes_inv_cipher_ctrl;

  localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_ctrl_if #(.KIDX_W(4)) bus0 ();
  aes_inv_cipher_ctrl_if #(.KIDX_W(4)) bus1 ();

  aes_inv_cipher_ctrl #(.NR(10), .KIDX_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aes_inv_cipher_ctrl #(.NR(14), .KIDX_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic         in_valid_v [2];
  logic [127:0] in_data_v  [2];
  logic         out_ready_v[2];
  logic         flush_v    [2];
  logic         rdy_w [2];
  logic         ov_w  [2];
  logic         busy_w[2];
  logic [3:0]   idx_w [2];
  logic [127:0] od_w  [2];
  logic [127:0] rk0 [16];
  logic [127:0] rk1 [16];

  assign bus0.in_valid = in_valid_v[0];  assign bus1.in_valid = in_valid_v[1];
  assign bus0.in_data  = in_data_v[0];   assign bus1.in_data  = in_data_v[1];
  assign bus0.out_ready = out_ready_v[0]; assign bus1.out_ready = out_ready_v[1];
  assign bus0.flush    = flush_v[0];     assign bus1.flush    = flush_v[1];
  assign bus0.rk_data  = rk0[bus0.rk_idx];
  assign bus1.rk_data  = rk1[bus1.rk_idx];
  assign rdy_w[0] = bus0.in_ready;   assign rdy_w[1] = bus1.in_ready;
  assign ov_w[0]  = bus0.out_valid;  assign ov_w[1]  = bus1.out_valid;
  assign busy_w[0] = bus0.busy;      assign busy_w[1] = bus1.busy;
  assign idx_w[0] = bus0.rk_idx;     assign idx_w[1] = bus1.rk_idx;
  assign od_w[0]  = bus0.out_data;   assign od_w[1]  = bus1.out_data;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  int           last_acc[2];
  logic         ov_prev[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nr_of(input int d);
    return (d == 1) ? 14 : 10;
  endfunction

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q0.size();
  endfunction

  function automatic logic [127:0] qpop(input int d);
    if (d == 1) return q1.pop_front();
    return q0.pop_front();
  endfunction

  // Reference arithmetic for the key-expansion model (forward S-box).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input int d, input logic [255:0] key, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] blk;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      blk = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
      if (d == 1) rk1[r] = blk;
      else        rk0[r] = blk;
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic accept(input int d, input logic [127:0] ct, input bit expect_out, input bit hold);
    int n;
    in_valid_v[d] = 1'b1;
    in_data_v[d]  = ct;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_w[d] && n < 60);
    if (!rdy_w[d]) begin
      check("accept_timeout", 128'(rdy_w[d]), 128'(1));
      in_valid_v[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc[d] = cyc;
    if (expect_out) begin
      if (d == 1) q1.push_back(ct == CT_C3 ? PT_C : 128'hx);
      else        q0.push_back(ct == CT_B ? PT_B : PT_C);
    end
    if (!hold) begin
      in_valid_v[d] = 1'b0;
      in_data_v[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_w[d] && n < 100);
    check("idle_timeout", 128'(rdy_w[d]), 128'(1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each out_valid rise, plaintext on each transfer.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ov_w[d] && !ov_prev[d])
        check($sformatf("latency_dut%0d", d), 128'(cyc - last_acc[d]), 128'(nr_of(d)));
      if (ov_w[d] && out_ready_v[d]) begin
        if (qsize(d) == 0) check($sformatf("spurious_out_dut%0d", d), 128'(ov_w[d]), '0);
        else               check($sformatf("plaintext_dut%0d", d), od_w[d], qpop(d));
      end
      ov_prev[d] = ov_w[d];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] cap;
    logic bad;
    int a1;
    for (int d = 0; d < 2; d++) begin
      in_valid_v[d] = 1'b0; in_data_v[d] = '0; out_ready_v[d] = 1'b1; flush_v[d] = 1'b0;
      last_acc[d] = 0; ov_prev[d] = 1'b0;
    end
    expand(0, KEY_C1, 4);
    expand(1, KEY_C3, 8);
    #1 rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready",  128'(rdy_w[d]),  128'(1));
      check("rst_out_valid", 128'(ov_w[d]),   '0);
      check("rst_busy",      128'(busy_w[d]), '0);
      check("rst_rk_idx",    128'(idx_w[d]),  128'(nr_of(d)));
      check("rst_out_data",  od_w[d],         '0);
    end
    #18 rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1
    accept(0, CT_C1, 1, 0);
    wait_idle(0);

    // Backpressure: output held for 20 cycles
    out_ready_v[0] = 1'b0;
    accept(0, CT_C1, 1, 0);
    bad = 1'b1;
    for (int n = 0; n < 60 && bad; n++) begin
      @(negedge clk);
      if (ov_w[0]) bad = 1'b0;
    end
    check("bp_valid_seen", 128'(ov_w[0]), 128'(1));
    cap = od_w[0];
    check("bp_data", cap, PT_C);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_hold", {ov_w[0], rdy_w[0], od_w[0]}, {1'b1, 1'b0, cap});
    end
    @(posedge clk); #1;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 128'(rdy_w[0]), 128'(1));
    check("bp_release_valid", 128'(ov_w[0]), '0);

    // Back-to-back with in_valid held high
    accept(0, CT_C1, 1, 1);
    a1 = last_acc[0];
    accept(0, CT_C1, 1, 0);
    check("b2b_interval", 128'(last_acc[0] - a1), 128'(12));
    wait_idle(0);

    // Flush together with in_valid in IDLE: not accepted
    in_valid_v[0] = 1'b1; in_data_v[0] = CT_C1; flush_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0; flush_v[0] = 1'b0;
    check("flush_idle_busy",  128'(busy_w[0]), '0);
    check("flush_idle_ready", 128'(rdy_w[0]),  128'(1));

    // Flush mid-round at rk_idx = 5
    accept(0, CT_C1, 0, 0);
    for (int n = 0; n < 20 && idx_w[0] != 4'd5; n++) @(negedge clk);
    check("flush_reach_idx5", 128'(idx_w[0]), 128'(5));
    flush_v[0] = 1'b1;
    @(posedge clk); #1;
    flush_v[0] = 1'b0;
    check("flush_ready",  128'(rdy_w[0]),  128'(1));
    check("flush_busy",   128'(busy_w[0]), '0);
    check("flush_rk_idx", 128'(idx_w[0]),  128'(10));
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      bad = bad | ov_w[0];
    end
    check("flush_no_out", 128'(bad), '0);
    @(posedge clk); #1;
    accept(0, CT_C1, 1, 0);
    wait_idle(0);

    // Asynchronous reset pulse between edges mid-round
    accept(0, CT_C1, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(ov_w[0]),  '0);
    check("arst_rk_idx",    128'(idx_w[0]), 128'(10));
    check("arst_in_ready",  128'(rdy_w[0]), 128'(1));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    accept(0, CT_C1, 1, 0);
    wait_idle(0);

    // FIPS-197 Appendix B key, loaded into the key store while idle
    expand(0, KEY_B, 4);
    accept(0, CT_B, 1, 0);
    wait_idle(0);

    // NR = 14 build with FIPS-197 C.3
    accept(1, CT_C3, 1, 0);
    wait_idle(1);

    repeat (3) @(posedge clk);
    check("queue0_drained", 128'(q0.size()), '0);
    check("queue1_drained", 128'(q1.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
